// File: rtl/video_pkt_pkg.sv
// Shared constants and types for the camera/UDP video packet path.
// The transmit-side packer uses the same header and resolution limits.
package video_pkt_pkg;

    localparam logic [31:0] IMG_FRAME_HEAD = 32'hF05AA50F;
    localparam logic [15:0] MAX_H_PIXEL    = 16'd640;
    localparam logic [15:0] MAX_V_PIXEL    = 16'd480;
    localparam logic [7:0]  VS_CYCLES      = 8'd16;
    localparam logic [7:0]  H_BLANK        = 8'd4;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_RES,
        ST_VS,
        ST_PIX,
        ST_BLANK
    } depkt_state_t;

    // H must be even so that every line ends on the second pixel of a word.
    function automatic logic res_valid(input logic [31:0] w);
        logic [15:0] h;
        logic [15:0] v;
        h = w[31:16];
        v = w[15:0];
        return (h != '0) && !h[0] && (h <= MAX_H_PIXEL) &&
               (v != '0) && (v <= MAX_V_PIXEL);
    endfunction

endpackage

// File: rtl/pkt_word_unpack.sv
// Splits a 32-bit packed word into two byte-swapped RGB565 pixels.
// ph=0 presents pixel A from the live word; ph=1 presents pixel B from the held half.
module pkt_word_unpack (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] in_data,
    output logic        ph,
    output logic [15:0] pix
);

    logic [15:0] hold;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            ph   <= 1'b0;
            hold <= '0;
        end else if (clr) begin
            ph   <= 1'b0;
        end else if (load) begin
            ph   <= 1'b1;
            hold <= in_data[15:0];
        end else if (advance) begin
            ph   <= 1'b0;
        end
    end

    always_comb begin
        if (ph)
            pix = {hold[7:0], hold[15:8]};
        else
            pix = {in_data[23:16], in_data[31:24]};
    end

endmodule

// File: rtl/img_data_depkt.sv
// Frame de-packetizer: hunts for the frame header, parses resolution and
// emits a camera-style pixel stream with vsync and line blanking.
module img_data_depkt
    import video_pkt_pkg::*;
(
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        rx_enable,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        img_vsync,
    output logic        img_data_en,
    output logic [15:0] img_data,
    output logic [15:0] img_h_pixel,
    output logic [15:0] img_v_pixel,
    output logic        frame_done,
    output logic        frame_err
);

    depkt_state_t state, state_nxt;
    logic [15:0]  x, x_nxt;
    logic [15:0]  y, y_nxt;
    logic [7:0]   cnt, cnt_nxt;
    logic         vsync_nxt, en_nxt, done_nxt, err_nxt;
    logic [15:0]  data_nxt, h_nxt, v_nxt;
    logic         ph, unpack_clr, unpack_load, unpack_adv;
    logic [15:0]  pix;
    logic         accept, is_head, emit;

    pkt_word_unpack u_unpack (
        .cam_pclk (cam_pclk),
        .rst_n    (rst_n),
        .clr      (unpack_clr),
        .load     (unpack_load),
        .advance  (unpack_adv),
        .in_data  (in_data),
        .ph       (ph),
        .pix      (pix)
    );

    always_comb begin
        in_ready = rx_enable &&
                   ((state == ST_HUNT) || (state == ST_RES) || ((state == ST_PIX) && !ph));
    end

    assign accept  = in_valid && in_ready;
    assign is_head = (in_data == IMG_FRAME_HEAD);
    assign emit    = (state == ST_PIX) && (ph || accept);

    always_comb begin
        state_nxt   = state;
        x_nxt       = x;
        y_nxt       = y;
        cnt_nxt     = cnt;
        vsync_nxt   = 1'b0;
        en_nxt      = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        data_nxt    = img_data;
        h_nxt       = img_h_pixel;
        v_nxt       = img_v_pixel;
        unpack_clr  = 1'b0;
        unpack_load = 1'b0;
        unpack_adv  = 1'b0;

        if (!rx_enable) begin
            state_nxt  = ST_HUNT;
            x_nxt      = '0;
            y_nxt      = '0;
            cnt_nxt    = '0;
            data_nxt   = '0;
            unpack_clr = 1'b1;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (accept && is_head)
                        state_nxt = ST_RES;
                end
                ST_RES: begin
                    // A repeated header simply re-arms RES.
                    if (accept && !is_head) begin
                        if (res_valid(in_data)) begin
                            h_nxt     = in_data[31:16];
                            v_nxt     = in_data[15:0];
                            state_nxt = ST_VS;
                            cnt_nxt   = '0;
                            vsync_nxt = 1'b1;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_HUNT;
                        end
                    end
                end
                ST_VS: begin
                    vsync_nxt = 1'b1;
                    cnt_nxt   = cnt + 8'd1;
                    if (cnt == VS_CYCLES - 8'd1) begin
                        vsync_nxt  = 1'b0;
                        cnt_nxt    = '0;
                        x_nxt      = '0;
                        y_nxt      = '0;
                        unpack_clr = 1'b1;
                        state_nxt  = ST_PIX;
                    end
                end
                ST_PIX: begin
                    if (emit) begin
                        en_nxt      = 1'b1;
                        data_nxt    = pix;
                        unpack_load = !ph;
                        unpack_adv  = ph;
                        if (x == img_h_pixel - 16'd1) begin
                            x_nxt = '0;
                            if (y == img_v_pixel - 16'd1) begin
                                y_nxt     = '0;
                                done_nxt  = 1'b1;
                                state_nxt = ST_HUNT;
                            end else begin
                                y_nxt     = y + 16'd1;
                                cnt_nxt   = '0;
                                state_nxt = ST_BLANK;
                            end
                        end else begin
                            x_nxt = x + 16'd1;
                        end
                    end
                end
                ST_BLANK: begin
                    cnt_nxt = cnt + 8'd1;
                    if (cnt == H_BLANK - 8'd1) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_PIX;
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HUNT;
            x           <= '0;
            y           <= '0;
            cnt         <= '0;
            img_vsync   <= 1'b0;
            img_data_en <= 1'b0;
            img_data    <= '0;
            img_h_pixel <= '0;
            img_v_pixel <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            cnt         <= cnt_nxt;
            img_vsync   <= vsync_nxt;
            img_data_en <= en_nxt;
            img_data    <= data_nxt;
            img_h_pixel <= h_nxt;
            img_v_pixel <= v_nxt;
            frame_done  <= done_nxt;
            frame_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_img_data_depkt.sv
// Self-checking bench for img_data_depkt: directed frames plus random pixel
// data and in_valid gaps against a byte-level reference model.
module tb_img_data_depkt;
    import video_pkt_pkg::*;

    logic        cam_pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_enable = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        img_vsync;
    logic        img_data_en;
    logic [15:0] img_data;
    logic [15:0] img_h_pixel;
    logic [15:0] img_v_pixel;
    logic        frame_done;
    logic        frame_err;

    img_data_depkt dut (
        .cam_pclk    (cam_pclk),
        .rst_n       (rst_n),
        .rx_enable   (rx_enable),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .img_vsync   (img_vsync),
        .img_data_en (img_data_en),
        .img_data    (img_data),
        .img_h_pixel (img_h_pixel),
        .img_v_pixel (img_v_pixel),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 cam_pclk = ~cam_pclk;

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;

    // Monitor: samples outputs on the falling edge.
    int          cyc = 0;
    logic [15:0] obs_pix[$];
    int          obs_cyc[$];
    int          done_cyc[$];
    int          vs_n = 0;
    int          err_n = 0;

    always @(negedge cam_pclk) begin
        cyc++;
        if (img_data_en) begin
            obs_pix.push_back(img_data);
            obs_cyc.push_back(cyc);
        end
        if (frame_done) done_cyc.push_back(cyc);
        if (img_vsync) vs_n++;
        if (frame_err) err_n++;
    end

    logic [31:0] tx_words[$];
    logic [15:0] exp_pix[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge cam_pclk);
            if (in_ready) begin
                @(posedge cam_pclk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        repeat (n) @(posedge cam_pclk);
        #1;
    endtask

    // Reference: each word carries two pixels, each pixel stored low byte first.
    task automatic model_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b3 = 8'((w >> 24) & 32'hFF);
        b2 = 8'((w >> 16) & 32'hFF);
        b1 = 8'((w >> 8) & 32'hFF);
        b0 = 8'(w & 32'hFF);
        exp_pix.push_back(16'(b2) * 16'd256 + 16'(b3));
        exp_pix.push_back(16'(b0) * 16'd256 + 16'(b1));
    endtask

    task automatic fill_random(input int unsigned n);
        tx_words.delete();
        for (int unsigned i = 0; i < n; i++) tx_words.push_back($urandom);
    endtask

    task automatic run_frame(input logic [15:0] h, input logic [15:0] v, input int unsigned max_gap);
        exp_pix.delete();
        send_word(IMG_FRAME_HEAD);
        send_word({h, v});
        foreach (tx_words[i]) begin
            if (max_gap > 0 && $urandom_range(0, 2) == 0)
                idle($urandom_range(1, max_gap));
            model_word(tx_words[i]);
            send_word(tx_words[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int dbase);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge cam_pclk);
            #1;
            if (done_cyc.size() > dbase) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge cam_pclk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] h, input logic [15:0] v,
                               input int pbase, input int dbase);
        int got;
        got = obs_pix.size() - pbase;
        check({tag, "_pix_count"}, 32'(got), 32'(h) * 32'(v));
        for (int i = 0; i < got && i < exp_pix.size(); i++)
            check({tag, "_pix"}, 32'(obs_pix[pbase + i]), 32'(exp_pix[i]));
        check({tag, "_done_count"}, 32'(done_cyc.size() - dbase), 32'd1);
        if (done_cyc.size() > dbase && got > 0)
            check({tag, "_done_on_last"}, 32'(done_cyc[dbase]), 32'(obs_cyc[obs_cyc.size() - 1]));
        check({tag, "_h"}, 32'(img_h_pixel), 32'(h));
        check({tag, "_v"}, 32'(img_v_pixel), 32'(v));
    endtask

    initial begin
        int pb, db, vb, eb;

        // Reset
        rx_enable = 1'b1;
        repeat (3) @(negedge cam_pclk);
        check("rst_vsync", 32'(img_vsync), 32'd0);
        check("rst_en", 32'(img_data_en), 32'd0);
        check("rst_data", 32'(img_data), 32'd0);
        check("rst_hv", {img_h_pixel, img_v_pixel}, 32'd0);
        check("rst_flags", {30'd0, frame_done, frame_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge cam_pclk);
        #1;

        // 4x2 frame, in_valid continuously high
        pb = obs_pix.size(); db = done_cyc.size(); vb = vs_n;
        tx_words.delete();
        tx_words.push_back(32'h11223344);
        tx_words.push_back(32'hA1B2C3D4);
        tx_words.push_back(32'h0badf00d);
        tx_words.push_back(32'hDEADBEEF);
        run_frame(16'd4, 16'd2, 0);
        wait_done(db);
        check_frame("f4x2", 16'd4, 16'd2, pb, db);
        check("f4x2_vsync_len", 32'(vs_n - vb), 32'(VS_CYCLES));
        check("f4x2_byte_a", 32'(obs_pix[pb]), 32'h2211);
        check("f4x2_byte_b", 32'(obs_pix[pb + 1]), 32'h4433);
        if (obs_cyc.size() >= pb + 8) begin
            check("f4x2_line0_burst", 32'(obs_cyc[pb + 3] - obs_cyc[pb]), 32'd3);
            check("f4x2_hblank", 32'(obs_cyc[pb + 4] - obs_cyc[pb + 3]), 32'(H_BLANK) + 32'd1);
            check("f4x2_line1_burst", 32'(obs_cyc[pb + 7] - obs_cyc[pb + 4]), 32'd3);
        end

        // Random data with random in_valid gaps
        for (int r = 0; r < 3; r++) begin
            pb = obs_pix.size(); db = done_cyc.size();
            fill_random(12);
            run_frame(16'd8, 16'd3, 4);
            wait_done(db);
            check_frame("rand", 16'd8, 16'd3, pb, db);
        end

        // Garbage, then rejected resolutions
        eb = err_n; vb = vs_n;
        send_word(32'h12345678);
        send_word(32'h00000000);
        send_word(32'hF05AA50E);
        send_word(IMG_FRAME_HEAD);
        send_word(32'h00030002);
        idle(2);
        check("err_odd_h", 32'(err_n - eb), 32'd1);
        send_word(32'h00020001);
        idle(20);
        check("hunt_after_err", 32'(vs_n - vb), 32'd0);
        send_word(IMG_FRAME_HEAD);
        send_word(32'h05000002);
        idle(20);
        check("err_big_h", 32'(err_n - eb), 32'd2);
        check("err_no_vsync", 32'(vs_n - vb), 32'd0);
        check("err_keeps_h", 32'(img_h_pixel), 32'd8);

        pb = obs_pix.size(); db = done_cyc.size();
        fill_random(2);
        run_frame(16'd2, 16'd2, 0);
        wait_done(db);
        check_frame("post_err", 16'd2, 16'd2, pb, db);

        // rx_enable dropped mid-line
        db = done_cyc.size();
        send_word(IMG_FRAME_HEAD);
        send_word({16'd4, 16'd2});
        send_word($urandom);
        send_word($urandom);
        rx_enable = 1'b0;
        in_valid = 1'b0;
        check("abort_ready", 32'(in_ready), 32'd0);
        @(posedge cam_pclk);
        @(negedge cam_pclk);
        check("abort_en", 32'(img_data_en), 32'd0);
        check("abort_vsync", 32'(img_vsync), 32'd0);
        repeat (10) @(posedge cam_pclk);
        #1;
        check("abort_no_done", 32'(done_cyc.size() - db), 32'd0);
        rx_enable = 1'b1;
        @(posedge cam_pclk);
        #1;
        pb = obs_pix.size(); db = done_cyc.size();
        fill_random(4);
        run_frame(16'd4, 16'd2, 2);
        wait_done(db);
        check_frame("reenable", 16'd4, 16'd2, pb, db);

        // Repeated header in RES, header value as pixel data
        pb = obs_pix.size(); db = done_cyc.size();
        exp_pix.delete();
        send_word(IMG_FRAME_HEAD);
        send_word(IMG_FRAME_HEAD);
        send_word({16'd2, 16'd1});
        model_word(IMG_FRAME_HEAD);
        send_word(IMG_FRAME_HEAD);
        in_valid = 1'b0;
        wait_done(db);
        check_frame("hdr_pix", 16'd2, 16'd1, pb, db);
        if (obs_pix.size() >= pb + 2) begin
            check("hdr_pix_a", 32'(obs_pix[pb]), 32'h5AF0);
            check("hdr_pix_b", 32'(obs_pix[pb + 1]), 32'h0FA5);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/img_data_depkt.md
# img_data_depkt

Frame de-packetizer for the camera/UDP video path, running in the cam_pclk domain. It takes 32-bit words, already moved into cam_pclk by an upstream receive FIFO, and hunts for the frame header 0xF05AA50F. It then parses the resolution word and unpacks two 16-bit pixels per word into a camera-style pixel stream (img_vsync, img_data_en, img_data) with line blanking inserted. Downstream, this stream feeds the display and frame-buffer writer exactly as a local sensor would.

## Interface
- IMG_FRAME_HEAD, 32'hF05AA50F: frame start marker.
- MAX_H_PIXEL, 16'd640: largest accepted horizontal resolution.
- MAX_V_PIXEL, 16'd480: largest accepted vertical resolution.
- VS_CYCLES, 8'd16: width of the img_vsync high pulse, in cycles.
- H_BLANK, 8'd4: cycles with img_data_en low between lines.

- cam_pclk  in  1  pixel clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_enable  in  1  when low, abort and hold in HUNT.
- in_valid  in  1  in_data is valid.
- in_data  in  32  packed word.
- in_ready  out  1  the word is consumed when in_valid and in_ready are both high.
- img_vsync  out  1  frame sync pulse, high at frame start.
- img_data_en  out  1  pixel valid.
- img_data  out  16  pixel, RGB565.
- img_h_pixel  out  16  latched horizontal resolution.
- img_v_pixel  out  16  latched vertical resolution.
- frame_done  out  1  1-cycle pulse after the last pixel of a frame.
- frame_err  out  1  1-cycle pulse when a resolution word is rejected.

## Operation
- Reset value of every output is 0. img_h_pixel and img_v_pixel hold their last accepted value until the next valid resolution word.
- States: HUNT, RES, VS, PIX, BLANK.
- HUNT: in_ready=1. Words other than IMG_FRAME_HEAD are discarded. On the header, go to RES.
- RES: in_ready=1. The accepted word gives H=w[31:16] and V=w[15:0].
  - Valid when H≠0, H even, H≤MAX_H_PIXEL, V≠0 and V≤MAX_V_PIXEL: latch H and V, go to VS.
  - Otherwise: pulse frame_err, go to HUNT.
  - A header word in RES restarts RES and is not treated as a resolution word.
- VS: in_ready=0. img_vsync=1 for VS_CYCLES cycles, then go to PIX with x=0 and y=0.
- PIX: each word is split into two pixels using phase bit ph.
  - ph=0: in_ready=1. On accept, emit pixel A={w[23:16],w[31:24]} and hold w[15:0]; ph←1.
  - ph=1: in_ready=0. Emit pixel B={w[7:0],w[15:8]}; ph←0.
  - If in_valid=0 while ph=0, img_data_en=0 for that cycle. Gaps are unbounded.
  - x increments once per emitted pixel.
  - At x=H-1: x←0 and y increments. If y=V-1, pulse frame_done together with the last pixel and go to HUNT; otherwise go to BLANK.
  - Pixel data is transparent: a header value arriving inside PIX is treated as pixel data.
- BLANK: in_ready=0, img_data_en=0 for H_BLANK cycles, then return to PIX.
- rx_enable=0 in any state forces the following within one cycle: HUNT, in_ready=0, img_vsync=0, img_data_en=0, and x, y, ph cleared. A partial frame produces no frame_done.
- Counters are 16-bit. x and y never exceed H-1 and V-1, so they cannot wrap.

## Timing
- All outputs are registered.
- A word accepted in PIX at edge N gives img_data_en=1 with pixel A in cycle N+1 and pixel B in cycle N+2.
- Peak throughput is 1 pixel per cycle, i.e. 1 word per 2 cycles.
- Header accepted at edge N: RES is active from N+1.
- Resolution word accepted at edge M: img_vsync is high from cycle M+1 through M+VS_CYCLES.
- in_ready is a combinational function of state and ph only; it does not depend on in_valid.
- frame_done is asserted in the same cycle as the final img_data_en.

## Structure
- Shared package, video_pkt_pkg: IMG_FRAME_HEAD, the default resolution constants, and the state enum. The existing transmit-side packer uses the same header and resolution constants.
- One natural sub-module, pkt_word_unpack: the ph register and the 32→16 byte-swap mux.
- The FSM and counters stay in the top module.

## Test plan
- H=4, V=2, with in_valid always high. Send header, 0x0004_0002, then 4 words. Expect:
  - a VS_CYCLES vsync pulse;
  - 4 pixels, then H_BLANK idle cycles, then 4 pixels;
  - frame_done on the 8th pixel;
  - img_h_pixel=4 and img_v_pixel=2.
- Byte order: word 0x11223344 gives img_data 0x2211, then 0x4433, on consecutive cycles.
- Random in_valid gaps in PIX: the pixel sequence and count are unchanged, and img_data_en is low only in gap and blank cycles.
- Three garbage words before the header are discarded. Resolution 0x0003_0002 (odd H) or 0x0500_0002 (H>640) gives a frame_err pulse and a return to HUNT with no vsync. A subsequent valid frame decodes normally.
- Drop rx_enable mid-line: outputs go to 0 the next cycle with no frame_done. After re-enable, the next header starts a clean frame.
- Header value 0xF05AA50F inside pixel data is output as pixels 0x5AF0 and 0x0FA5.
